// File: rtl/elevator_door_ctrl_if.sv
// Signal bundle between the car controller side and the door sequencer.
//   Controller/cabin side (master) drives:
//     move, floor_number[2:0], obstruct, open_btn, close_btn
//   Door sequencer (slave) drives:
//     door_motor_open, door_motor_close, door_is_open, door_closed,
//     hold, arrived_floor[2:0], nudge, move_err
interface elevator_door_ctrl_if;
  logic       move;
  logic [2:0] floor_number;
  logic       obstruct;
  logic       open_btn;
  logic       close_btn;

  logic       door_motor_open;
  logic       door_motor_close;
  logic       door_is_open;
  logic       door_closed;
  logic       hold;
  logic [2:0] arrived_floor;
  logic       nudge;
  logic       move_err;

  modport master (
    output move, floor_number, obstruct, open_btn, close_btn,
    input  door_motor_open, door_motor_close, door_is_open, door_closed,
           hold, arrived_floor, nudge, move_err
  );

  modport slave (
    input  move, floor_number, obstruct, open_btn, close_btn,
    output door_motor_open, door_motor_close, door_is_open, door_closed,
           hold, arrived_floor, nudge, move_err
  );
endinterface

// File: rtl/elevator_door_ctrl.sv
// Elevator door sequencer. Opens the door at every service stop (falling edge
// of move) or on the open button while parked, dwells, then closes. Obstruction
// or the open button reverses a closing door up to MAX_REOPEN times, after
// which nudge mode ignores further reversal requests until the door is closed.
//   clock    : single rising-edge clock
//   reset    : asynchronous, active-high
//   bus      : elevator_door_ctrl_if.slave
//              in : move, floor_number, obstruct, open_btn, close_btn
//              out: door_motor_open, door_motor_close, door_is_open,
//                   door_closed, hold, arrived_floor, nudge, move_err
module elevator_door_ctrl #(
  parameter int OPEN_CYCLES  = 4,
  parameter int DWELL_CYCLES = 8,
  parameter int CLOSE_CYCLES = 4,
  parameter int MAX_REOPEN   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  elevator_door_ctrl_if.slave   bus
);

  localparam int MAX_OD  = (OPEN_CYCLES > DWELL_CYCLES) ? OPEN_CYCLES : DWELL_CYCLES;
  localparam int MAX_ALL = (MAX_OD > CLOSE_CYCLES) ? MAX_OD : CLOSE_CYCLES;
  localparam int TW      = $clog2(MAX_ALL + 1);
  localparam int RW      = $clog2(MAX_REOPEN + 1);

  localparam logic [TW-1:0] T_OPEN  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_DWELL = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] T_CLOSE = TW'(CLOSE_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(MAX_REOPEN - 1);

  typedef enum logic [1:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   reopen_cnt;
  logic            move_q;
  logic [2:0]      arrived_floor;
  logic            nudge;
  logic            move_err;
  logic            motor_open;
  logic            motor_close;
  logic            is_open;
  logic            closed;

  logic            stop_event;
  logic            reopen_req;

  assign stop_event = move_q & ~bus.move;
  assign reopen_req = bus.obstruct | bus.open_btn;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= CLOSED;
      timer         <= '0;
      reopen_cnt    <= '0;
      move_q        <= 1'b0;
      arrived_floor <= '0;
      nudge         <= 1'b0;
      move_err      <= 1'b0;
      motor_open    <= 1'b0;
      motor_close   <= 1'b0;
      is_open       <= 1'b0;
      closed        <= 1'b1;
    end else begin
      move_q <= bus.move;

      // Protocol watchdog only; never influences sequencing.
      if (bus.move && (state != CLOSED)) begin
        move_err <= 1'b1;
      end

      // Decoded outputs are written alongside each state change so they
      // always mirror the registered state.
      case (state)
        CLOSED: begin
          if (stop_event || (bus.open_btn && !bus.move)) begin
            state         <= OPENING;
            timer         <= T_OPEN;
            arrived_floor <= bus.floor_number;
            closed        <= 1'b0;
            motor_open    <= 1'b1;
          end
        end

        OPENING: begin
          if (timer == '0) begin
            state      <= OPEN;
            timer      <= T_DWELL;
            motor_open <= 1'b0;
            is_open    <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        OPEN: begin
          if (reopen_req) begin
            timer <= T_DWELL;
          end else if (bus.close_btn || (timer == '0)) begin
            state       <= CLOSING;
            timer       <= T_CLOSE;
            is_open     <= 1'b0;
            motor_close <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        CLOSING: begin
          if (reopen_req && !nudge) begin
            state       <= OPENING;
            timer       <= T_OPEN;
            reopen_cnt  <= reopen_cnt + RW'(1);
            motor_close <= 1'b0;
            motor_open  <= 1'b1;
            // This reversal exhausts the allowance.
            if (reopen_cnt == R_LAST) begin
              nudge <= 1'b1;
            end
          end else if (timer == '0) begin
            state       <= CLOSED;
            reopen_cnt  <= '0;
            nudge       <= 1'b0;
            motor_close <= 1'b0;
            closed      <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end

        default: begin
          state       <= CLOSED;
          timer       <= '0;
          motor_open  <= 1'b0;
          motor_close <= 1'b0;
          is_open     <= 1'b0;
          closed      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.door_motor_open  = motor_open;
  assign bus.door_motor_close = motor_close;
  assign bus.door_is_open     = is_open;
  assign bus.door_closed      = closed;
  // Combinational term lets the inhibit rise in the very cycle the stop is seen.
  assign bus.hold             = ~closed | stop_event;
  assign bus.arrived_floor    = arrived_floor;
  assign bus.nudge            = nudge;
  assign bus.move_err         = move_err;

endmodule

// File: tb/tb_elevator_door_ctrl.sv
// Self-checking bench for elevator_door_ctrl: directed scenarios plus a
// randomized run, all compared against a phase/elapsed-time model.
module tb_elevator_door_ctrl;
  localparam int OPEN_N  = 4;
  localparam int DWELL_N = 8;
  localparam int CLOSE_N = 4;
  localparam int MAXR    = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  elevator_door_ctrl_if dbus();

  elevator_door_ctrl #(
    .OPEN_CYCLES (OPEN_N),
    .DWELL_CYCLES(DWELL_N),
    .CLOSE_CYCLES(CLOSE_N),
    .MAX_REOPEN  (MAXR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (dbus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: door phase plus cycles elapsed in it.
  typedef enum {M_CLOSED, M_OPENING, M_OPEN, M_CLOSING} mphase_t;
  mphase_t ph;
  int      elapsed, reversals, m_floor;
  bit      m_nudge, m_err, m_prev;

  function automatic void model_reset();
    ph = M_CLOSED; elapsed = 0; reversals = 0; m_floor = 0;
    m_nudge = 0; m_err = 0; m_prev = 0;
  endfunction

  function automatic void model_clock(bit mv, int fl, bit ob, bit op, bit cl);
    bit stop;
    stop = m_prev && !mv;
    if (mv && ph != M_CLOSED) m_err = 1;
    case (ph)
      M_CLOSED:
        if (stop || (op && !mv)) begin
          ph = M_OPENING; elapsed = 0; m_floor = fl;
        end
      M_OPENING: begin
        elapsed++;
        if (elapsed == OPEN_N) begin ph = M_OPEN; elapsed = 0; end
      end
      M_OPEN:
        if (ob || op) elapsed = 0;
        else begin
          elapsed++;
          if (cl || elapsed == DWELL_N) begin ph = M_CLOSING; elapsed = 0; end
        end
      M_CLOSING:
        if ((ob || op) && !m_nudge) begin
          ph = M_OPENING; elapsed = 0; reversals++;
          if (reversals == MAXR) m_nudge = 1;
        end else begin
          elapsed++;
          if (elapsed == CLOSE_N) begin
            ph = M_CLOSED; elapsed = 0; reversals = 0; m_nudge = 0;
          end
        end
      default: ph = M_CLOSED;
    endcase
    m_prev = mv;
  endfunction

  // Sampled DUT outputs and per-scenario tallies.
  logic       s_hold, s_closed, s_open, s_nudge, s_err;
  logic [2:0] s_arrived;
  int         n_mo, n_op, n_mc, n_nudge;

  task automatic clear_tally();
    n_mo = 0; n_op = 0; n_mc = 0; n_nudge = 0;
  endtask

  // Called just after a falling edge: drive, sample, check, clock the model.
  task automatic step(input bit mv, input int fl, input bit ob, input bit op, input bit cl);
    dbus.move         = mv;
    dbus.floor_number = 3'(fl);
    dbus.obstruct     = ob;
    dbus.open_btn     = op;
    dbus.close_btn    = cl;
    #1;
    s_hold    = dbus.hold;
    s_closed  = dbus.door_closed;
    s_open    = dbus.door_is_open;
    s_nudge   = dbus.nudge;
    s_err     = dbus.move_err;
    s_arrived = dbus.arrived_floor;
    n_mo    += int'(dbus.door_motor_open);
    n_op    += int'(dbus.door_is_open);
    n_mc    += int'(dbus.door_motor_close);
    n_nudge += int'(dbus.nudge);
    check("closed",  32'(dbus.door_closed),      32'(ph == M_CLOSED));
    check("m_open",  32'(dbus.door_motor_open),  32'(ph == M_OPENING));
    check("is_open", 32'(dbus.door_is_open),     32'(ph == M_OPEN));
    check("m_close", 32'(dbus.door_motor_close), 32'(ph == M_CLOSING));
    check("hold",    32'(dbus.hold),             32'((ph != M_CLOSED) || (m_prev && !mv)));
    check("arrived", 32'(dbus.arrived_floor),    32'(m_floor));
    check("nudge",   32'(dbus.nudge),            32'(m_nudge));
    check("move_err",32'(dbus.move_err),         32'(m_err));
    @(posedge clock);
    model_clock(mv, fl, ob, op, cl);
    @(negedge clock);
  endtask

  task automatic idle(input int n, input int fl);
    repeat (n) step(0, fl, 0, 0, 0);
  endtask

  // Reset asserted between clock edges; outputs must react without a clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    dbus.move = 0; dbus.obstruct = 0; dbus.open_btn = 0; dbus.close_btn = 0;
    #1;
    check({tag, "_closed"},  32'(dbus.door_closed),      32'd1);
    check({tag, "_hold"},    32'(dbus.hold),             32'd0);
    check({tag, "_mopen"},   32'(dbus.door_motor_open),  32'd0);
    check({tag, "_isopen"},  32'(dbus.door_is_open),     32'd0);
    check({tag, "_mclose"},  32'(dbus.door_motor_close), 32'd0);
    check({tag, "_arrived"}, 32'(dbus.arrived_floor),    32'd0);
    check({tag, "_nudge"},   32'(dbus.nudge),            32'd0);
    check({tag, "_err"},     32'(dbus.move_err),         32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Open via the button, then pulse stimulus in OPEN cycle number idx (0-based).
  task automatic dwell_case(input string tag, input int idx, input bit ob, input bit op,
                            input bit cl, input int exp_open);
    int k;
    bit hit;
    k = 0;
    clear_tally();
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      hit = (ph == M_OPEN) && (k == idx);
      if (ph == M_OPEN) k++;
      step(0, 1, hit & ob, hit & op, hit & cl);
    end
    check({tag, "_open_cycles"}, 32'(n_op),     32'(exp_open));
    check({tag, "_end_closed"},  32'(s_closed), 32'd1);
  endtask

  initial begin
    bit mv;
    int fl, k;
    reset = 1'b1;
    dbus.move = 0; dbus.floor_number = 3'd1; dbus.obstruct = 0;
    dbus.open_btn = 0; dbus.close_btn = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check("rst_closed", 32'(dbus.door_closed), 32'd1);
    check("rst_hold",   32'(dbus.hold),        32'd0);
    reset = 1'b0;

    // Normal stop at floor 3.
    repeat (3) step(1, 2, 0, 0, 0);
    clear_tally();
    step(0, 3, 0, 0, 0);
    check("stop_hold_same_cycle", 32'(s_hold),   32'd1);
    check("stop_still_closed",    32'(s_closed), 32'd1);
    idle(20, 3);
    check("stop_motor_open_cycles",  32'(n_mo), 32'd4);
    check("stop_open_cycles",        32'(n_op), 32'd8);
    check("stop_motor_close_cycles", 32'(n_mc), 32'd4);
    check("stop_arrived",            32'(s_arrived), 32'd3);
    check("stop_end_hold",           32'(s_hold),    32'd0);

    // Dwell control.
    dwell_case("btn_extend",   5, 0, 1, 0, 14);
    dwell_case("close_early",  1, 0, 0, 1, 2);
    dwell_case("close_vs_obs", 1, 1, 0, 1, 10);

    // Nudge: obstruct whenever the door is closing.
    clear_tally();
    step(0, 5, 0, 1, 0);
    for (int i = 0; i < 70; i++) step(0, 5, ph == M_CLOSING, 0, 0);
    check("nudge_opening_cycles", 32'(n_mo),     32'd16);
    check("nudge_closing_cycles", 32'(n_mc),     32'd7);
    check("nudge_high_cycles",    32'(n_nudge),  32'd16);
    check("nudge_end_clear",      32'(s_nudge),  32'd0);
    check("nudge_end_closed",     32'(s_closed), 32'd1);

    // Protocol violation: move high for one cycle while open.
    clear_tally();
    k = 0;
    step(0, 2, 0, 1, 0);
    for (int i = 0; i < 25; i++) begin
      mv = (ph == M_OPEN) && (k == 2);
      if (ph == M_OPEN) k++;
      step(mv, 2, 0, 0, 0);
    end
    check("err_open_cycles",  32'(n_op),     32'd8);
    check("err_mopen_cycles", 32'(n_mo),     32'd4);
    check("err_mclose_cycles",32'(n_mc),     32'd4);
    check("err_sticky",       32'(s_err),    32'd1);
    check("err_end_closed",   32'(s_closed), 32'd1);
    async_reset("err_rst");

    // Open button ignored while moving.
    clear_tally();
    repeat (4) step(1, 2, 0, 1, 0);
    check("btn_moving_no_open", 32'(n_mo),     32'd0);
    check("btn_moving_closed",  32'(s_closed), 32'd1);
    idle(20, 2);

    // Reset in the middle of OPEN.
    step(0, 4, 0, 1, 0);
    idle(7, 4);
    check("pre_rst_open", 32'(s_open), 32'd1);
    async_reset("mid_open_rst");

    // Randomized controller-like traffic.
    mv = 0;
    fl = 1;
    for (int i = 0; i < 3000; i++) begin
      if (ph == M_CLOSED) begin
        if ($urandom_range(5) == 0) mv = !mv;
      end else begin
        mv = ($urandom_range(79) == 0);
      end
      if (mv && $urandom_range(3) == 0) fl = 1 + int'($urandom_range(4));
      step(mv, fl, $urandom_range(9) == 0, $urandom_range(14) == 0, $urandom_range(7) == 0);
      if (i % 500 == 499) async_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
